// File: rtl/esp_uart_bridge.sv
// Memory-mapped bridge between the aq32 CPU bus and the ESP32 co-processor UART.
// TX/RX FIFOs plus 9-bit-frame serial transmitter and receiver (bit 8 = command marker).

module esp_uart_bridge_fifo #(
   parameter int unsigned AW = 4,
   parameter int unsigned DW = 9
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] head_c,
   output logic          empty_c,
   output logic          full_c,
   output logic          accept_c
);
   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned PW    = AW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_pop;

   assign empty_c  = (wr_ptr == rd_ptr);
   assign full_c   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign do_pop   = pop && !empty_c;
   // A pop in the same cycle frees the slot the push lands in
   assign accept_c = push && (!full_c || do_pop);
   assign head_c   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (accept_c) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)   rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (accept_c) mem[wr_ptr[AW-1:0]] <= wdata;
   end
endmodule

module esp_uart_bridge #(
   parameter int unsigned BAUD_DIV = 16,
   parameter int unsigned FIFO_AW  = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        bus_addr,
   input  logic [31:0] bus_wrdata,
   input  logic        bus_wren,
   input  logic        bus_rden,
   output logic [31:0] bus_rddata,
   output logic        uart_txd,
   input  logic        uart_rxd,
   input  logic        uart_cts_n
);
   localparam int unsigned CW = 16;
   localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   tx_state_t     tx_state, tx_state_n;
   logic [CW-1:0] tx_cnt, tx_cnt_n;
   logic [3:0]    tx_bit, tx_bit_n;
   logic [8:0]    tx_sh, tx_sh_n;
   logic          txd_n;
   logic          tx_pop_c, tx_go_c, tx_tick_c;

   rx_state_t     rx_state, rx_state_n;
   logic [CW-1:0] rx_cnt, rx_cnt_n;
   logic [3:0]    rx_bit, rx_bit_n;
   logic [8:0]    rx_sh, rx_sh_n;
   logic          rx_push_c, ferr_set_c, rx_tick_c, rx_fall_c;

   logic rx_s1, rx_s2, rx_prev, cts_s1, cts_s2;
   logic ovf, ferr;

   logic [8:0] tx_head, rx_head;
   logic       tx_empty, tx_full, tx_accept;
   logic       rx_empty, rx_full, rx_accept;

   logic wr_data_c, wr_stat_c, rd_data_c, rd_stat_c;
   logic [31:0] status_c;
   logic unused_c;

   // Write wins when both strobes are asserted
   assign wr_data_c = bus_wren && bus_addr;
   assign wr_stat_c = bus_wren && !bus_addr;
   assign rd_data_c = bus_rden && !bus_wren && bus_addr;
   assign rd_stat_c = bus_rden && !bus_wren && !bus_addr;

   assign status_c = {27'b0, (tx_empty && tx_state == TX_IDLE), ferr, ovf, tx_full, !rx_empty};
   assign unused_c = ^{bus_wrdata[31:9], tx_accept, rx_full};

   esp_uart_bridge_fifo #(.AW(FIFO_AW), .DW(9)) u_tx_fifo (
      .clk(clk), .reset_n(reset_n), .push(wr_data_c), .wdata(bus_wrdata[8:0]),
      .pop(tx_pop_c), .head_c(tx_head), .empty_c(tx_empty), .full_c(tx_full),
      .accept_c(tx_accept)
   );

   esp_uart_bridge_fifo #(.AW(FIFO_AW), .DW(9)) u_rx_fifo (
      .clk(clk), .reset_n(reset_n), .push(rx_push_c), .wdata(rx_sh_n),
      .pop(rd_data_c), .head_c(rx_head), .empty_c(rx_empty), .full_c(rx_full),
      .accept_c(rx_accept)
   );

   assign tx_go_c   = !tx_empty && !cts_s2;
   assign tx_tick_c = (tx_cnt == BIT_END);
   assign rx_tick_c = (rx_cnt == BIT_END);
   assign rx_fall_c = rx_prev && !rx_s2;

   // TX next-state: txd_n is the line level for the next cycle
   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_bit_n   = tx_bit;
      tx_sh_n    = tx_sh;
      txd_n      = uart_txd;
      tx_pop_c   = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            txd_n = 1'b1;
            if (tx_go_c) begin
               tx_pop_c   = 1'b1;
               tx_sh_n    = tx_head;
               tx_cnt_n   = '0;
               txd_n      = 1'b0;
               tx_state_n = TX_START;
            end
         end
         TX_START: begin
            if (tx_tick_c) begin
               tx_cnt_n   = '0;
               tx_bit_n   = '0;
               txd_n      = tx_sh[0];
               tx_sh_n    = tx_sh >> 1;
               tx_state_n = TX_DATA;
            end else tx_cnt_n = tx_cnt + CW'(1);
         end
         TX_DATA: begin
            if (tx_tick_c) begin
               tx_cnt_n = '0;
               if (tx_bit == 4'd8) begin
                  txd_n      = 1'b1;
                  tx_state_n = TX_STOP;
               end else begin
                  txd_n    = tx_sh[0];
                  tx_sh_n  = tx_sh >> 1;
                  tx_bit_n = tx_bit + 4'd1;
               end
            end else tx_cnt_n = tx_cnt + CW'(1);
         end
         TX_STOP: begin
            if (tx_tick_c) begin
               tx_cnt_n = '0;
               // Chain straight into the next start bit with no idle gap
               if (tx_go_c) begin
                  tx_pop_c   = 1'b1;
                  tx_sh_n    = tx_head;
                  txd_n      = 1'b0;
                  tx_state_n = TX_START;
               end else begin
                  txd_n      = 1'b1;
                  tx_state_n = TX_IDLE;
               end
            end else tx_cnt_n = tx_cnt + CW'(1);
         end
         default: tx_state_n = TX_IDLE;
      endcase
   end

   // RX next-state: edge-triggered start, so after a framing error the line must rise first
   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt;
      rx_bit_n   = rx_bit;
      rx_sh_n    = rx_sh;
      rx_push_c  = 1'b0;
      ferr_set_c = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (rx_fall_c) begin
               rx_cnt_n   = '0;
               rx_state_n = RX_START;
            end
         end
         RX_START: begin
            if (rx_cnt == HALF_END) begin
               rx_cnt_n   = '0;
               rx_bit_n   = '0;
               rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
            end else rx_cnt_n = rx_cnt + CW'(1);
         end
         RX_DATA: begin
            if (rx_tick_c) begin
               rx_cnt_n = '0;
               rx_sh_n  = {rx_s2, rx_sh[8:1]};
               if (rx_bit == 4'd8) rx_state_n = RX_STOP;
               else                rx_bit_n   = rx_bit + 4'd1;
            end else rx_cnt_n = rx_cnt + CW'(1);
         end
         RX_STOP: begin
            if (rx_tick_c) begin
               rx_cnt_n   = '0;
               rx_state_n = RX_IDLE;
               if (rx_s2) rx_push_c  = 1'b1;
               else       ferr_set_c = 1'b1;
            end else rx_cnt_n = rx_cnt + CW'(1);
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tx_state   <= TX_IDLE;
         tx_cnt     <= '0;
         tx_bit     <= '0;
         tx_sh      <= '0;
         uart_txd   <= 1'b1;
         rx_state   <= RX_IDLE;
         rx_cnt     <= '0;
         rx_bit     <= '0;
         rx_sh      <= '0;
         rx_s1      <= 1'b1;
         rx_s2      <= 1'b1;
         rx_prev    <= 1'b1;
         cts_s1     <= 1'b1;
         cts_s2     <= 1'b1;
         ovf        <= 1'b0;
         ferr       <= 1'b0;
         bus_rddata <= '0;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_bit   <= tx_bit_n;
         tx_sh    <= tx_sh_n;
         uart_txd <= txd_n;
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_bit   <= rx_bit_n;
         rx_sh    <= rx_sh_n;
         rx_s1    <= uart_rxd;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         cts_s1   <= uart_cts_n;
         cts_s2   <= cts_s1;
         ovf  <= (ovf  && !(wr_stat_c && bus_wrdata[2])) || (rx_push_c && !rx_accept);
         ferr <= (ferr && !(wr_stat_c && bus_wrdata[3])) || ferr_set_c;
         if (rd_stat_c)      bus_rddata <= status_c;
         else if (rd_data_c) bus_rddata <= rx_empty ? 32'h0 : {23'b0, rx_head};
      end
   end
endmodule

// File: tb/tb_esp_uart_bridge.sv
// Scoreboard bench for esp_uart_bridge: bus reads and TX frames are checked
// by monitors against expectations queued when stimulus is issued.

module tb_esp_uart_bridge;
   localparam int BD = 16;
   localparam int FRAME = 11 * BD;

   logic        clk;
   logic        reset_n;
   logic        bus_addr;
   logic [31:0] bus_wrdata;
   logic        bus_wren;
   logic        bus_rden;
   logic [31:0] bus_rddata;
   logic        uart_txd;
   logic        uart_rxd;
   logic        uart_cts_n;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_q[$];
   string       nm_q[$];
   logic [8:0]  tx_q[$];
   logic        rd_seen;

   logic [10:0] tm_fb;
   logic [8:0]  tm_d;
   logic        tm_ok, tm_abort, tm_has;

   esp_uart_bridge #(.BAUD_DIV(BD), .FIFO_AW(4)) dut (
      .clk(clk), .reset_n(reset_n), .bus_addr(bus_addr), .bus_wrdata(bus_wrdata),
      .bus_wren(bus_wren), .bus_rden(bus_rden), .bus_rddata(bus_rddata),
      .uart_txd(uart_txd), .uart_rxd(uart_rxd), .uart_cts_n(uart_cts_n)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", n, act, exp);
      end
   endtask

   // Read data is valid the cycle after an accepted read strobe
   always @(posedge clk) rd_seen <= bus_rden && !bus_wren;

   initial begin
      forever begin
         @(negedge clk);
         if (rd_seen === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_read: got=%h expected=none", bus_rddata);
            end else begin
               check(nm_q.pop_front(), bus_rddata, exp_q.pop_front());
            end
         end
      end
   end

   // TX monitor: every bit of a frame must hold for exactly BD cycles
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n === 1'b1 && uart_txd === 1'b0) begin
            tm_has   = (tx_q.size() != 0);
            tm_d     = tm_has ? tx_q.pop_front() : 9'h0;
            tm_fb    = {1'b1, tm_d, 1'b0};
            tm_ok    = 1'b1;
            tm_abort = 1'b0;
            for (int i = 0; i < FRAME; i++) begin
               if (i > 0) @(negedge clk);
               if (reset_n !== 1'b1) begin
                  tm_abort = 1'b1;
                  break;
               end
               if (uart_txd !== tm_fb[i / BD]) tm_ok = 1'b0;
            end
            if (!tm_abort) begin
               total++;
               if (!tm_has || !tm_ok) begin
                  bad++;
                  $display("FAIL tx_frame: got bits_ok=%0d queued=%0d expected data=%h", tm_ok, tm_has, tm_d);
               end
            end
         end
      end
   end

   task automatic bus_write(input logic a, input logic [31:0] d);
      @(negedge clk);
      bus_addr   = a;
      bus_wrdata = d;
      bus_wren   = 1'b1;
      @(negedge clk);
      bus_wren   = 1'b0;
   endtask

   task automatic bus_read(input logic a, input logic [31:0] e, input string n);
      exp_q.push_back(e);
      nm_q.push_back(n);
      @(negedge clk);
      bus_addr = a;
      bus_rden = 1'b1;
      @(negedge clk);
      bus_rden = 1'b0;
   endtask

   task automatic send_rx(input logic [8:0] d, input logic stop);
      logic [10:0] fb;
      fb = {stop, d, 1'b0};
      for (int b = 0; b < 11; b++) begin
         @(negedge clk);
         uart_rxd = fb[b];
         repeat (BD - 1) @(negedge clk);
      end
      @(negedge clk);
      uart_rxd = 1'b1;
   endtask

   initial begin
      logic ok;
      reset_n    = 1'b0;
      bus_addr   = 1'b0;
      bus_wrdata = '0;
      bus_wren   = 1'b0;
      bus_rden   = 1'b0;
      uart_rxd   = 1'b1;
      uart_cts_n = 1'b0;
      repeat (4) @(negedge clk);
      check("rddata_reset", bus_rddata, 32'h0);
      check("txd_reset", 32'(uart_txd), 32'h1);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      bus_read(1'b0, 32'h10, "status_after_reset");
      ok = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (uart_txd !== 1'b1) ok = 1'b0;
      end
      check("txd_idle_100", 32'(ok), 32'h1);

      tx_q.push_back(9'h11F);
      bus_write(1'b1, 32'h11F);
      repeat (FRAME + 30) @(negedge clk);
      bus_read(1'b0, 32'h10, "status_tx_done");

      send_rx(9'h0A5, 1'b1);
      repeat (4) @(negedge clk);
      bus_read(1'b0, 32'h11, "status_rx_ready");
      bus_read(1'b1, 32'h0A5, "rx_data_a5");
      bus_read(1'b0, 32'h10, "status_rx_drained");

      for (int k = 1; k <= 17; k++) send_rx(9'(k) | ((k % 2) ? 9'h100 : 9'h0), 1'b1);
      repeat (4) @(negedge clk);
      bus_read(1'b0, 32'h15, "status_overflow");
      for (int k = 1; k <= 16; k++) bus_read(1'b1, 32'(9'(k) | ((k % 2) ? 9'h100 : 9'h0)), "rx_fifo_order");
      bus_read(1'b0, 32'h14, "status_ovf_sticky");
      bus_write(1'b0, 32'h4);
      bus_read(1'b0, 32'h10, "status_ovf_cleared");

      send_rx(9'h055, 1'b0);
      repeat (4) @(negedge clk);
      bus_read(1'b0, 32'h18, "status_framing");
      bus_read(1'b1, 32'h0, "rx_empty_read");
      bus_write(1'b0, 32'h8);
      bus_read(1'b0, 32'h10, "status_ferr_cleared");
      @(negedge clk);
      uart_rxd = 1'b0;
      repeat (3) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (40) @(negedge clk);
      bus_read(1'b0, 32'h10, "status_after_glitch");

      uart_cts_n = 1'b1;
      repeat (4) @(negedge clk);
      for (int k = 0; k < 16; k++) begin
         tx_q.push_back(9'(32'h30 + k) | ((k % 3 == 0) ? 9'h100 : 9'h0));
         bus_write(1'b1, 32'(9'(32'h30 + k) | ((k % 3 == 0) ? 9'h100 : 9'h0)));
      end
      bus_read(1'b0, 32'h02, "status_tx_full");
      bus_write(1'b1, 32'h1FF);
      repeat (50) @(negedge clk);
      check("txd_held_by_cts", 32'(uart_txd), 32'h1);
      uart_cts_n = 1'b0;
      repeat (17 * FRAME + 40) @(negedge clk);
      check("tx_sixteen_frames", 32'(tx_q.size()), 32'h0);
      bus_read(1'b0, 32'h10, "status_tx_drained");

      tx_q.push_back(9'h0AA);
      bus_write(1'b1, 32'h0AA);
      repeat (60) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("txd_after_midframe_reset", 32'(uart_txd), 32'h1);
      @(negedge clk);
      reset_n = 1'b1;
      tx_q.delete();
      repeat (3) @(negedge clk);
      bus_read(1'b0, 32'h10, "status_after_midframe_reset");
      repeat (5) @(negedge clk);
      check("read_queue_drained", 32'(exp_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
